// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states,
// RV32 byte/half/word store masking and load extension, error on misaligned/illegal access.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DEPTH_WORDS = 512,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic [3:0]            counter, counter_next;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic [2:0]            lat_funct3;
  logic                  accept, req_illegal, do_access, set_err;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [31:0]           acc_wdata;
  logic [2:0]            acc_funct3;
  logic [IDX_W-1:0]      acc_idx;
  logic [3:0]            byte_en;
  logic [31:0]           wdata_lanes;
  logic [31:0]           rd_word, load_data;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic is_illegal(input logic we, input logic [1:0] a, input logic [2:0] f3);
    case (f3)
      3'b000:  is_illegal = 1'b0;
      3'b001:  is_illegal = a[0];
      3'b010:  is_illegal = (a != 2'b00);
      3'b100:  is_illegal = we;
      3'b101:  is_illegal = we | a[0];
      default: is_illegal = 1'b1;
    endcase
  endfunction

  assign accept      = (state == IDLE) && req_valid && !rst;
  assign req_illegal = is_illegal(req_we, req_addr[1:0], req_funct3);
  assign req_ready   = (state == IDLE) && !rst;
  assign rsp_valid   = (state == RESP);
  assign busy        = (state != IDLE);

  // With zero wait states the access happens on the accept edge, straight from the request inputs.
  assign acc_we     = (state == IDLE) ? req_we     : lat_we;
  assign acc_addr   = (state == IDLE) ? req_addr   : lat_addr;
  assign acc_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;
  assign acc_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;
  assign acc_idx    = acc_addr[ADDR_WIDTH-1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      counter <= 4'd0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    do_access    = 1'b0;
    set_err      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_illegal) begin
            set_err    = 1'b1;
            state_next = RESP;
          end else if (WAIT_CYCLES == 0) begin
            do_access  = 1'b1;
            state_next = RESP;
          end else begin
            counter_next = WAIT_LOAD;
            state_next   = WAIT;
          end
        end
      end
      WAIT: begin
        counter_next = counter - 4'd1;
        if (counter == 4'd1) begin
          do_access  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target lane(s).
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = 32'h0;
    case (acc_funct3[1:0])
      2'b00: begin
        byte_en     = 4'b0001 << acc_addr[1:0];
        wdata_lanes = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        byte_en     = acc_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{acc_wdata[15:0]}};
      end
      default: begin
        byte_en     = 4'b1111;
        wdata_lanes = acc_wdata;
      end
    endcase
  end

  always_comb begin
    rd_word = mem[acc_idx];
    rd_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_funct3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_data = {24'h0, rd_byte};
      3'b101:  load_data = {16'h0, rd_half};
      default: load_data = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_access && acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[acc_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= 32'h0;
      lat_funct3 <= 3'b000;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        lat_we     <= req_we;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        lat_funct3 <= req_funct3;
      end
      if (set_err) rsp_err <= 1'b1;
      if (do_access && !acc_we) rsp_rdata <= load_data;
      if ((state == RESP) && rsp_ready) begin
        rsp_rdata <= 32'h0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance a uses one wait state, instance b uses four.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_we;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_valid_a, req_valid_b, rsp_ready_a, rsp_ready_b;
  logic        req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b;
  logic [31:0] rsp_rdata_a, rsp_rdata_b;
  logic        rsp_err_a, rsp_err_b, busy_a, busy_b;

  logic        sel_b;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_busy;
  logic [31:0] o_rsp_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(11), .DEPTH_WORDS(512), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_rdata(rsp_rdata_a),
    .rsp_err(rsp_err_a), .busy(busy_a)
  );

  dmem_responder #(.ADDR_WIDTH(11), .DEPTH_WORDS(512), .WAIT_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
    .rsp_err(rsp_err_b), .busy(busy_b)
  );

  always_comb begin
    o_req_ready = sel_b ? req_ready_b : req_ready_a;
    o_rsp_valid = sel_b ? rsp_valid_b : rsp_valid_a;
    o_rsp_rdata = sel_b ? rsp_rdata_b : rsp_rdata_a;
    o_rsp_err   = sel_b ? rsp_err_b   : rsp_err_a;
    o_busy      = sel_b ? busy_b      : busy_a;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic setReqValid(input logic v);
    if (sel_b) req_valid_b = v; else req_valid_a = v;
  endtask

  task automatic setRspReady(input logic v);
    if (sel_b) rsp_ready_b = v; else rsp_ready_a = v;
  endtask

  // Returns at the negedge following the accept edge, with req_valid dropped.
  task automatic issueReq(input logic we, input logic [10:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3);
    int k = 0;
    while (!o_req_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) checkOutput("req_ready_timeout", 32'(o_req_ready), 32'd1);
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    setReqValid(1'b1);
    @(posedge clk);
    @(negedge clk);
    setReqValid(1'b0);
  endtask

  // Latency is the number of edges after the accept edge before rsp_valid is seen.
  task automatic waitRsp(input string tag, input logic [31:0] exp_data, input logic exp_err,
                         input int exp_lat);
    int k = 0;
    while (!o_rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_lat"}, 32'(k), 32'(exp_lat));
    checkOutput({tag, "_data"}, o_rsp_rdata, exp_data);
    checkOutput({tag, "_err"}, 32'(o_rsp_err), 32'(exp_err));
  endtask

  task automatic finishRsp(input string tag);
    setRspReady(1'b1);
    @(posedge clk);
    @(negedge clk);
    setRspReady(1'b0);
    checkOutput({tag, "_clr_valid"}, 32'(o_rsp_valid), 32'd0);
    checkOutput({tag, "_clr_data"}, o_rsp_rdata, 32'd0);
  endtask

  task automatic applyStimulus(input string tag, input logic we, input logic [10:0] addr,
                               input logic [31:0] wdata, input logic [2:0] f3,
                               input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    issueReq(we, addr, wdata, f3);
    waitRsp(tag, exp_data, exp_err, exp_lat);
    finishRsp(tag);
  endtask

  initial begin
    sel_b       = 1'b0;
    rst         = 1'b1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    rsp_ready_a = 1'b0;
    rsp_ready_b = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_funct3  = 3'b010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(o_req_ready), 32'd0);
    rst = 1'b0;
    checkOutput("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    checkOutput("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    checkOutput("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    checkOutput("idle_req_ready", 32'(o_req_ready), 32'd1);

    applyStimulus("sw_010", 1'b1, 11'h010, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 1);
    applyStimulus("lw_010", 1'b0, 11'h010, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 1);
    applyStimulus("sw_020", 1'b1, 11'h020, 32'h80FF7F01, 3'b010, 32'h0, 1'b0, 1);
    applyStimulus("lb_021", 1'b0, 11'h021, 32'h0, 3'b000, 32'h0000007F, 1'b0, 1);
    applyStimulus("lb_023", 1'b0, 11'h023, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, 1);
    applyStimulus("lbu_023", 1'b0, 11'h023, 32'h0, 3'b100, 32'h00000080, 1'b0, 1);
    applyStimulus("lh_022", 1'b0, 11'h022, 32'h0, 3'b001, 32'hFFFF80FF, 1'b0, 1);
    applyStimulus("lhu_022", 1'b0, 11'h022, 32'h0, 3'b101, 32'h000080FF, 1'b0, 1);
    applyStimulus("sb_020", 1'b1, 11'h020, 32'h123456AA, 3'b000, 32'h0, 1'b0, 1);
    applyStimulus("lw_020", 1'b0, 11'h020, 32'h0, 3'b010, 32'h80FF7FAA, 1'b0, 1);
    applyStimulus("sh_032", 1'b1, 11'h032, 32'h9999BEEF, 3'b001, 32'h0, 1'b0, 1);
    applyStimulus("lhu_032", 1'b0, 11'h032, 32'h0, 3'b101, 32'h0000BEEF, 1'b0, 1);

    applyStimulus("lw_mis", 1'b0, 11'h012, 32'h0, 3'b010, 32'h0, 1'b1, 0);
    applyStimulus("sh_mis", 1'b1, 11'h011, 32'h0000FFFF, 3'b001, 32'h0, 1'b1, 0);
    applyStimulus("lw_010b", 1'b0, 11'h010, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 1);
    applyStimulus("f3_011", 1'b0, 11'h010, 32'h0, 3'b011, 32'h0, 1'b1, 0);
    applyStimulus("sbu_ill", 1'b1, 11'h010, 32'h00000055, 3'b100, 32'h0, 1'b1, 0);
    applyStimulus("lw_010c", 1'b0, 11'h010, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 1);

    // Backpressure with a competing request held on the request channel.
    issueReq(1'b0, 11'h010, 32'h0, 3'b010);
    waitRsp("bp_lw", 32'hDEADBEEF, 1'b0, 1);
    req_we     = 1'b0;
    req_addr   = 11'h022;
    req_funct3 = 3'b101;
    req_valid_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", 32'(o_rsp_valid), 32'd1);
      checkOutput("bp_data", o_rsp_rdata, 32'hDEADBEEF);
      checkOutput("bp_err", 32'(o_rsp_err), 32'd0);
      checkOutput("bp_req_ready", 32'(o_req_ready), 32'd0);
    end
    rsp_ready_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_a = 1'b0;
    checkOutput("bp_hs_busy", 32'(o_busy), 32'd0);
    checkOutput("bp_hs_req_ready", 32'(o_req_ready), 32'd1);
    checkOutput("bp_hs_valid", 32'(o_rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid_a = 1'b0;
    checkOutput("bp_next_busy", 32'(o_busy), 32'd1);
    waitRsp("bp_lhu", 32'h000080FF, 1'b0, 1);
    finishRsp("bp_lhu");

    // Four wait states, then a store aborted by reset in WAIT.
    sel_b = 1'b1;
    @(negedge clk);
    applyStimulus("b_sw0", 1'b1, 11'h040, 32'h00000000, 3'b010, 32'h0, 1'b0, 4);
    applyStimulus("b_sw044", 1'b1, 11'h044, 32'hCAFE0001, 3'b010, 32'h0, 1'b0, 4);
    applyStimulus("b_lh046", 1'b0, 11'h046, 32'h0, 3'b001, 32'hFFFFCAFE, 1'b0, 4);
    applyStimulus("b_lw_mis", 1'b0, 11'h041, 32'h0, 3'b010, 32'h0, 1'b1, 0);
    issueReq(1'b1, 11'h040, 32'h12345678, 3'b010);
    checkOutput("b_abort_busy", 32'(o_busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("b_abort_rst_valid", 32'(o_rsp_valid), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("b_abort_valid", 32'(o_rsp_valid), 32'd0);
      checkOutput("b_abort_idle", 32'(o_busy), 32'd0);
    end
    applyStimulus("b_lw040", 1'b0, 11'h040, 32'h0, 3'b010, 32'h00000000, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
